// File: rtl/lut_config_loader_if.sv
// Bitstream stream handshake between the fabric port and the loader.
// master drives bs_data/bs_valid, slave returns bs_ready.
interface lut_config_loader_if #(
  parameter int IN_WIDTH = 1
) ();
  logic [IN_WIDTH-1:0] bs_data;
  logic                bs_valid;
  logic                bs_ready;

  modport master (
    output bs_data,
    output bs_valid,
    input  bs_ready
  );

  modport slave (
    input  bs_data,
    input  bs_valid,
    output bs_ready
  );
endinterface

// File: rtl/lut_config_loader.sv
// Assembles a bitstream into MEM_SIZE-bit words and writes them to LUT 0..N-1.
// Ports: cclk/crst/start, bs (stream slave), config_out, one-hot cen, busy, done.
module lut_config_loader #(
  parameter int MEM_SIZE = 16,
  parameter int NUM_LUTS = 4,
  parameter int IN_WIDTH = 1
) (
  input  logic                cclk,
  input  logic                crst,
  input  logic                start,
  lut_config_loader_if.slave  bs,
  output logic [MEM_SIZE-1:0] config_out,
  output logic [NUM_LUTS-1:0] cen,
  output logic                busy,
  output logic                done
);

  localparam int BEATS = MEM_SIZE / IN_WIDTH;
  localparam int CW    = $clog2(BEATS + 1);
  localparam int IW    = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;

  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  localparam logic [IW-1:0] LAST_LUT  = IW'(NUM_LUTS - 1);

  generate
    if (MEM_SIZE % IN_WIDTH != 0) begin : g_bad_width
      $error("MEM_SIZE must be a multiple of IN_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] beat;
  logic [IW-1:0] idx;

  logic [MEM_SIZE-1:0] shift_nxt;
  logic                accept;

  // First beat of a word ends up in the MSBs.
  generate
    if (IN_WIDTH == MEM_SIZE) begin : g_full
      assign shift_nxt = bs.bs_data;
    end else begin : g_shift
      assign shift_nxt = {config_out[MEM_SIZE-IN_WIDTH-1:0], bs.bs_data};
    end
  endgenerate

  assign accept = bs.bs_valid && bs.bs_ready;

  always_ff @(posedge cclk) begin
    if (crst) begin
      state       <= IDLE;
      beat        <= '0;
      idx         <= '0;
      config_out  <= '0;
      cen         <= '0;
      bs.bs_ready <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cen  <= '0;
          done <= 1'b0;
          if (start) begin
            state       <= LOAD;
            beat        <= '0;
            idx         <= '0;
            busy        <= 1'b1;
            bs.bs_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            config_out <= shift_nxt;
            beat       <= beat + CW'(1);
            if (beat == LAST_BEAT) begin
              state       <= WRITE;
              bs.bs_ready <= 1'b0;
              cen         <= NUM_LUTS'(1) << idx;
            end
          end
        end
        WRITE: begin
          cen  <= '0;
          beat <= '0;
          if (idx == LAST_LUT) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx         <= idx + IW'(1);
            state       <= LOAD;
            bs.bs_ready <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lut_config_loader.sv
// Bench for lut_config_loader: default, 4-bit beat and single-LUT builds.
// Random valid gaps, mid-session reset and start-while-busy are exercised.
module tb_lut_config_loader;

  logic cclk = 1'b0;
  always #5 cclk = ~cclk;

  int checks = 0;
  int errors = 0;

  // default build 16/4/1
  logic        rst_a, start_a;
  logic [15:0] cfg_a;
  logic [3:0]  cen_a;
  logic        busy_a, done_a;
  lut_config_loader_if #(.IN_WIDTH(1)) bs_a ();

  lut_config_loader #(
    .MEM_SIZE(16), .NUM_LUTS(4), .IN_WIDTH(1)
  ) dut_a (
    .cclk(cclk), .crst(rst_a), .start(start_a), .bs(bs_a.slave),
    .config_out(cfg_a), .cen(cen_a), .busy(busy_a), .done(done_a)
  );

  // nibble build 16/4/4
  logic        rst_b, start_b;
  logic [15:0] cfg_b;
  logic [3:0]  cen_b;
  logic        busy_b, done_b;
  lut_config_loader_if #(.IN_WIDTH(4)) bs_b ();

  lut_config_loader #(
    .MEM_SIZE(16), .NUM_LUTS(4), .IN_WIDTH(4)
  ) dut_b (
    .cclk(cclk), .crst(rst_b), .start(start_b), .bs(bs_b.slave),
    .config_out(cfg_b), .cen(cen_b), .busy(busy_b), .done(done_b)
  );

  // single-LUT build 16/1/1
  logic        rst_c, start_c;
  logic [15:0] cfg_c;
  logic [0:0]  cen_c;
  logic        busy_c, done_c;
  lut_config_loader_if #(.IN_WIDTH(1)) bs_c ();

  lut_config_loader #(
    .MEM_SIZE(16), .NUM_LUTS(1), .IN_WIDTH(1)
  ) dut_c (
    .cclk(cclk), .crst(rst_c), .start(start_c), .bs(bs_c.slave),
    .config_out(cfg_c), .cen(cen_c), .busy(busy_c), .done(done_c)
  );

  logic [15:0] words [4];

  task automatic step();
    @(posedge cclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Streams words[0..3] MSB-first into dut_a and checks every cycle
  // against the expected schedule: a cen one cycle after each 16th bit,
  // done one cycle after the last cen. rst_at >= 0 stops early at that
  // bit count; sp >= 0 raises start while that bit count is pending.
  task automatic run_a(input int duty, input int rst_at, input int sp);
    int   acc, cyc, ncen;
    bit   v, took, fin, prev_last;
    logic [3:0] ecen;
    logic       edone;
    acc = 0; cyc = 0; ncen = 0; fin = 0; prev_last = 0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("a_busy_start", busy_a, 1);
    chk("a_ready_start", bs_a.bs_ready, 1);
    while (!fin && cyc < 3000) begin
      if (rst_at >= 0 && acc == rst_at) break;
      v = (acc < 64) && ($urandom_range(99) < duty);
      bs_a.bs_valid = v;
      bs_a.bs_data = v ? words[acc/16][15-(acc%16)] : 1'($urandom_range(1));
      start_a = (sp >= 0 && acc == sp);
      took = v && bs_a.bs_ready;
      step();
      cyc++;
      if (took) acc++;
      ecen  = (took && acc % 16 == 0) ? 4'(4'd1 << (acc/16 - 1)) : 4'd0;
      edone = prev_last;
      chk("a_cen", cen_a, ecen);
      chk("a_done", done_a, edone);
      chk("a_ready", bs_a.bs_ready, (acc < 64) && ecen == 4'd0);
      chk("a_busy", busy_a, (acc < 64) || ecen != 4'd0);
      if (ecen != 4'd0) begin
        ncen++;
        chk("a_word", cfg_a, words[acc/16 - 1]);
      end
      prev_last = (ecen == 4'b1000);
      fin = edone;
    end
    bs_a.bs_valid = 1'b0;
    start_a = 1'b0;
    if (rst_at < 0) begin
      chk("a_timeout", fin, 1);
      chk("a_cen_count", ncen, 4);
      step();
      chk("a_idle_busy", busy_a, 0);
      chk("a_idle_ready", bs_a.bs_ready, 0);
      chk("a_idle_cen", cen_a, 0);
      chk("a_idle_done", done_a, 0);
      chk("a_hold_word", cfg_a, words[3]);
    end
  endtask

  initial begin
    logic [15:0] w, wc;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    bs_a.bs_valid = 1'b0; bs_a.bs_data = '0;
    bs_b.bs_valid = 1'b0; bs_b.bs_data = '0;
    bs_c.bs_valid = 1'b0; bs_c.bs_data = '0;
    step();
    step();
    chk("rst_cfg", cfg_a, 0);
    chk("rst_cen", cen_a, 0);
    chk("rst_ready", bs_a.bs_ready, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_b_cen", cen_b, 0);
    chk("rst_c_busy", busy_c, 0);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    step();

    // back-to-back words
    words[0] = 16'hA5C3; words[1] = 16'h0001;
    words[2] = 16'h8000; words[3] = 16'hFFFF;
    run_a(100, -1, -1);

    // random valid gaps
    for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
    run_a(50, -1, -1);

    // reset after 9 bits of LUT 1, with start and valid high
    run_a(60, 25, -1);
    rst_a = 1'b1;
    start_a = 1'b1;
    bs_a.bs_valid = 1'b1;
    bs_a.bs_data = 1'b1;
    step();
    chk("mrst_cfg", cfg_a, 0);
    chk("mrst_cen", cen_a, 0);
    chk("mrst_busy", busy_a, 0);
    chk("mrst_ready", bs_a.bs_ready, 0);
    chk("mrst_done", done_a, 0);
    rst_a = 1'b0;
    start_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_cen", cen_a, 0);
      chk("post_rst_busy", busy_a, 0);
    end
    bs_a.bs_valid = 1'b0;
    for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
    run_a(100, -1, -1);

    // start pulsed while busy
    for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
    run_a(70, -1, 20);

    // nibble build: 0x1234 into LUT 0
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bs_b.bs_valid = 1'b1;
      bs_b.bs_data = 4'(i + 1);
      step();
      if (i < 3) begin
        chk("b_cen_early", cen_b, 0);
        chk("b_ready", bs_b.bs_ready, 1);
      end
    end
    bs_b.bs_valid = 1'b0;
    chk("b_cen0", cen_b, 4'b0001);
    chk("b_word0", cfg_b, 16'h1234);
    chk("b_ready_write", bs_b.bs_ready, 0);
    chk("b_busy", busy_b, 1);
    step();
    chk("b_cen_off", cen_b, 0);
    chk("b_ready_back", bs_b.bs_ready, 1);
    w = 16'($urandom);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        bs_b.bs_valid = 1'b0;
        step();
        chk("b_stall_ready", bs_b.bs_ready, 1);
      end
      bs_b.bs_valid = 1'b1;
      bs_b.bs_data = w[15-4*i -: 4];
      step();
    end
    bs_b.bs_valid = 1'b0;
    chk("b_cen1", cen_b, 4'b0010);
    chk("b_word1", cfg_b, w);

    // single-LUT build
    wc = 16'h7E81;
    start_c = 1'b1;
    step();
    start_c = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bs_c.bs_valid = 1'b1;
      bs_c.bs_data = wc[15-i];
      step();
      if (i < 15) chk("c_cen_early", cen_c, 0);
    end
    bs_c.bs_valid = 1'b0;
    chk("c_cen", cen_c, 1);
    chk("c_word", cfg_c, 16'h7E81);
    chk("c_busy_write", busy_c, 1);
    step();
    chk("c_done", done_c, 1);
    chk("c_cen_off", cen_c, 0);
    chk("c_busy_done", busy_c, 0);
    step();
    chk("c_done_off", done_c, 0);
    chk("c_idle_busy", busy_c, 0);
    chk("c_hold", cfg_c, 16'h7E81);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
